// File: rtl/systolic_drain_if.sv
// systolic_drain_if: packed result-row stream from systolic_drain to the writeback path.
// master drives rows (data/valid/last), slave returns ready.
interface systolic_drain_if #(
   parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16,
   parameter int unsigned DATA_WIDTH_ACCUM     = 32
);
   logic signed [DATA_WIDTH_ACCUM-1:0] out_data [SYSTOLIC_ARRAY_WIDTH];
   logic                               out_valid;
   logic                               out_ready;
   logic                               out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/systolic_drain.sv
// systolic_drain: deskews the systolic array's bottom-edge psums, masks unused columns and
// buffers whole result rows in a FIFO drained over valid/ready. Macro: SYSTOLIC_DRAIN_RELU_EN.
module systolic_drain #(
   parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16,
   parameter int unsigned DATA_WIDTH_ACCUM     = 32,
   parameter int unsigned FIFO_DEPTH           = 4
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic signed [DATA_WIDTH_ACCUM-1:0]           sys_data_in [SYSTOLIC_ARRAY_WIDTH],
   input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]              sys_valid_in,
   input  logic [$clog2(SYSTOLIC_ARRAY_WIDTH+1)-1:0]    col_size_in,
   input  logic [$clog2(SYSTOLIC_ARRAY_WIDTH+1)-1:0]    tile_rows_in,
   input  logic                                         cfg_valid_in,
   systolic_drain_if.master                             out_if,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]              fifo_count,
   output logic                                         overflow,
   output logic                                         skew_err,
   input  logic                                         err_clear
);

   localparam int unsigned W   = SYSTOLIC_ARRAY_WIDTH;
   localparam int unsigned DW  = DATA_WIDTH_ACCUM;
   localparam int unsigned FD  = FIFO_DEPTH;
   localparam int unsigned CW  = $clog2(W + 1);
   localparam int unsigned FCW = $clog2(FD + 1);
   localparam int unsigned PW  = $clog2(FD);

   logic [W-1:0][DW-1:0] dsk_data;
   logic [W-1:0]         dsk_valid;

   // Column j waits W-1-j cycles so every column of a row lines up with column W-1.
   for (genvar j = 0; j < int'(W); j++) begin : g_col
      localparam int unsigned DEPTH = W - 1 - j;
      if (DEPTH == 0) begin : g_pass
         assign dsk_data[j]  = sys_data_in[j];
         assign dsk_valid[j] = sys_valid_in[j];
      end else begin : g_pipe
         logic [DW-1:0]    sr_data [DEPTH];
         logic [DEPTH-1:0] sr_valid;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < int'(DEPTH); i++) sr_data[i] <= '0;
               sr_valid <= '0;
            end else begin
               sr_data[0] <= sys_data_in[j];
               for (int i = 1; i < int'(DEPTH); i++) sr_data[i] <= sr_data[i-1];
               sr_valid <= DEPTH'({sr_valid, sys_valid_in[j]});
            end
         end

         assign dsk_data[j]  = sr_data[DEPTH-1];
         assign dsk_valid[j] = sr_valid[DEPTH-1];
      end
   end

   logic [CW-1:0]        col_size_q;
   logic [CW-1:0]        tile_rows_q;
   logic [CW-1:0]        row_cnt_q;
   logic [FCW-1:0]       count_q;
   logic [PW-1:0]        wr_ptr_q;
   logic [PW-1:0]        rd_ptr_q;
   logic                 valid_q;
   logic                 last_q;
   logic                 overflow_q;
   logic                 skew_q;
   logic [W-1:0][DW-1:0] mem [FD];

   logic [W-1:0][DW-1:0] row_w;
   logic                 skew_hit;

   // Masked (and optionally rectified) row as it will be stored; skew check on enabled columns.
   always_comb begin
      row_w    = '0;
      skew_hit = 1'b0;
      for (int j = 0; j < int'(W); j++) begin
         if (j < int'(col_size_q)) begin
`ifdef SYSTOLIC_DRAIN_RELU_EN
            row_w[j] = dsk_data[j][DW-1] ? '0 : dsk_data[j];
`else
            row_w[j] = dsk_data[j];
`endif
            if (dsk_valid[j] != dsk_valid[0]) skew_hit = 1'b1;
         end
      end
   end

   logic           strobe;
   logic           pop;
   logic           push;
   logic           drop;
   logic           full;
   logic [FCW-1:0] count_nxt;
   logic [CW-1:0]  tile_nxt;
   logic [CW-1:0]  eff_nxt;
   logic [CW-1:0]  row_cnt_nxt;
   logic           last_nxt;

   // FIFO and tile bookkeeping; out_valid/out_last are precomputed for the next cycle.
   always_comb begin
      strobe    = dsk_valid[0];
      pop       = valid_q & out_if.out_ready;
      full      = (count_q == FCW'(FD));
      push      = strobe & (~full | pop);
      drop      = strobe & full & ~pop;
      count_nxt = count_q + FCW'(push) - FCW'(pop);

      tile_nxt  = cfg_valid_in ? tile_rows_in : tile_rows_q;
      eff_nxt   = (tile_nxt == '0) ? CW'(W) : tile_nxt;

      row_cnt_nxt = row_cnt_q;
      if (cfg_valid_in) begin
         row_cnt_nxt = '0;
      end else if (pop) begin
         row_cnt_nxt = last_q ? '0 : row_cnt_q + CW'(1);
      end

      last_nxt = (count_nxt != '0) && (row_cnt_nxt == eff_nxt - CW'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FD); i++) mem[i] <= '0;
         wr_ptr_q <= '0;
      end else if (push) begin
         mem[wr_ptr_q] <= row_w;
         wr_ptr_q      <= wr_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q    <= '0;
         count_q     <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         row_cnt_q   <= '0;
         col_size_q  <= '0;
         tile_rows_q <= '0;
         overflow_q  <= 1'b0;
         skew_q      <= 1'b0;
      end else begin
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q   <= count_nxt;
         valid_q   <= (count_nxt != '0);
         last_q    <= last_nxt;
         row_cnt_q <= row_cnt_nxt;
         if (cfg_valid_in) begin
            col_size_q  <= col_size_in;
            tile_rows_q <= tile_rows_in;
         end
         overflow_q <= err_clear ? 1'b0 : (overflow_q | drop);
         skew_q     <= err_clear ? 1'b0 : (skew_q | skew_hit);
      end
   end

   always_comb begin
      for (int j = 0; j < int'(W); j++) out_if.out_data[j] = mem[rd_ptr_q][j];
   end

   assign out_if.out_valid = valid_q;
   assign out_if.out_last  = last_q;
   assign fifo_count       = count_q;
   assign overflow         = overflow_q;
   assign skew_err         = skew_q;

endmodule

// File: doc/systolic_drain.md
# systolic_drain

Output-side stage directly downstream of the 16x16 systolic array. It takes the per-column int32 partial sums leaving the array's bottom edge. Column j's result for a given row arrives j cycles after column 0's, so the block delays each column to line the columns up. It then masks unused columns, packs one full result row and buffers rows in a small FIFO. The FIFO drains over a valid/ready interface to the result writeback path, with end-of-tile marking and sticky overflow and skew error flags.

## Interface
- SYSTOLIC_ARRAY_WIDTH, 16, columns W of the array
- DATA_WIDTH_ACCUM, 32, partial-sum width
- FIFO_DEPTH, 4, rows buffered; power of two, >= 2
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sys_data_in[W]  in  signed DATA_WIDTH_ACCUM each  array bottom-edge psums
- sys_valid_in[W]  in  1 each  per-column valid, aligned with sys_data_in
- col_size_in  in  $clog2(W+1)  number of active columns
- tile_rows_in  in  $clog2(W+1)  rows per tile; 0 means W
- cfg_valid_in  in  1  latches col_size_in and tile_rows_in
- out_data[W]  out  signed DATA_WIDTH_ACCUM each  packed result row
- out_valid  out  1  row available
- out_ready  in  1  consumer accepts row
- out_last  out  1  row is last of tile
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupancy
- overflow  out  1  sticky: row dropped on full FIFO
- skew_err  out  1  sticky: enabled column misaligned with column 0
- err_clear  in  1  clears overflow and skew_err

## Operation
- **Deskew.** Column j passes through a shift register of W-1-j stages carrying both data and valid. Column W-1 uses zero stages. After deskew, all columns of one row are present in the same cycle.
- **Row strobe.** The row strobe is the deskewed valid of column 0.
- **Column masking.** Columns j >= col_size_q are written as 0.
- **Skew error.** When any enabled column's deskewed valid differs from column 0's, set skew_err. Rows are still handled normally.
- **Configuration register.** col_size_q and tile_rows_q load on cfg_valid_in. Both reset to 0. Changing them while a row is inside the deskew pipe is legal. The values in effect on the FIFO-write cycle apply.
- **FIFO write and read.**
  - On a row strobe, write the masked row at wr_ptr.
  - Pop on out_valid && out_ready.
  - out_data is driven from the entry at rd_ptr. Both pointers wrap modulo FIFO_DEPTH.
- **Full FIFO.**
  - Strobe with fifo_count==FIFO_DEPTH and no pop in the same cycle: drop the row and set overflow.
  - Strobe and pop in the same cycle while full: both happen, and the count stays at FIFO_DEPTH.
- **Empty FIFO.** out_valid=0 and out_ready is ignored.
- **Tile counter.** row_cnt counts popped rows.
  - out_last = out_valid && (row_cnt == tile_rows_eff-1), where tile_rows_eff = (tile_rows_q==0) ? W : tile_rows_q.
  - On a pop with out_last=1, row_cnt wraps to 0.
  - A cfg_valid_in pulse also resets row_cnt to 0.
- **Error flags.** err_clear has priority over a same-cycle set.
- **Reset.** rst_n low clears every register, including the deskew pipes, pointers, row_cnt and flags. Rows in flight are lost.
  - Reset values: out_valid=0, out_last=0, fifo_count=0, overflow=0, skew_err=0.
  - out_data reads as 0: FIFO storage is cleared.

## Timing
- Let t be the cycle in which column 0's valid is present at sys_valid_in.
  - Column W-1's valid for the same row arrives in cycle t+W-1.
  - The row is written into the FIFO at the edge ending cycle t+W-1.
  - With an empty FIFO, out_valid rises in cycle t+W. Latency is W cycles (16 by default).
- Throughput is one row per cycle in and one row per cycle out.
- out_data, out_valid and out_last are registered or come straight from FIFO storage, with no combinational path from sys_* inputs.
- out_valid depends only on fifo_count and does not depend on out_ready.
- fifo_count updates the cycle after a push or pop.
- overflow and skew_err assert the cycle after the causing event.

## Configuration
- SYSTOLIC_DRAIN_RELU_EN defined: at FIFO write, each enabled column value below 0 is replaced by 0 (ReLU). Masked columns stay 0.
- SYSTOLIC_DRAIN_RELU_EN undefined: values are stored unmodified, two's complement.

## Test plan
- Reset, col_size=16, tile_rows=4, out_ready=1. Drive column j with valid at cycle 10+j and data 100+j. Expect: out_valid first in cycle 26, out_data[j]=100+j, skew_err=0.
- col_size=4. Drive all 16 columns with data -5, properly skewed. Expect: out_data[0..3]=-5 (0 with SYSTOLIC_DRAIN_RELU_EN), out_data[4..15]=0.
- out_ready=0, 6 back-to-back rows, FIFO_DEPTH=4. Expect: fifo_count saturates at 4, overflow=1, rows 5 and 6 dropped. Raise out_ready and expect rows 1-4 in order, then out_valid=0.
- FIFO full, row strobe and pop in the same cycle. Expect: fifo_count stays 4, overflow stays 0, new row appears in order.
- tile_rows=3, stream 7 rows. Expect: out_last on rows 3 and 6 only. tile_rows=0 gives out_last on row 16.
- Column 5 valid one cycle late, col_size=16. Expect: skew_err=1 next cycle. err_clear pulse gives skew_err=0. Assert rst_n low mid-stream and expect out_valid=0, fifo_count=0 immediately.
